// File: rtl/timer_dev_pkg.sv
// Shared definitions for the bus timer: FSM states, register offsets,
// CTRL bit positions and MODE codes.
package timer_dev_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_PSC    = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Upper CTRL bits are not stored and always read back as zero.
   function automatic logic [31:0] ctrl_read(input logic en, input logic [1:0] mode,
                                             input logic im);
      return {28'd0, im, mode, en};
   endfunction

endpackage

// File: rtl/timer_dev_prescaler.sv
// Tick generator for the timer count stage: one tick every psc+1 cycles.
// Only built when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_dev_prescaler #(
   parameter int PSC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [PSC_W-1:0] psc,
   output logic             tick
);

   logic [PSC_W-1:0] div;

   // Comparing with >= keeps the divider sane if psc shrinks mid-count.
   assign tick = (div >= psc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div <= '0;
      else if (clr || tick)
         div <= '0;
      else
         div <= div + PSC_W'(1);
   end

endmodule
`endif

// File: rtl/timer_dev.sv
// Programmable down-counting bus timer raising the CP0 interrupt request.
// Optional prescaler on addr 3 enabled by defining TIMER_PRESCALE_EN.
module timer_dev
   import timer_dev_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int PSC_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   state_t             state, state_next;
   logic               en, en_next, im;
   logic [1:0]         mode;
   logic [CNT_W-1:0]   preset, count, count_next;
   logic               pending, pending_next;
   logic [PSC_W-1:0]   psc;
   logic               tick;

   logic               ctrl_wr, preset_wr, bus_wr;
   logic               en_wr, im_wr;
   logic [1:0]         mode_wr;

   assign ctrl_wr   = we && (addr == ADDR_CTRL);
   assign preset_wr = we && (addr == ADDR_PRESET);
   assign bus_wr    = ctrl_wr || preset_wr;

   // CTRL as it stands after this edge, so a CPU write always wins over the FSM.
   assign en_wr   = ctrl_wr ? din[CTRL_EN] : en;
   assign mode_wr = ctrl_wr ? din[CTRL_MODE_HI:CTRL_MODE_LO] : mode;
   assign im_wr   = ctrl_wr ? din[CTRL_IM] : im;

`ifdef TIMER_PRESCALE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         psc <= '0;
      else if (we && (addr == ADDR_PSC))
         psc <= din[PSC_W-1:0];
   end

   timer_dev_prescaler #(.PSC_W(PSC_W)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == LOAD),
      .psc  (psc),
      .tick (tick)
   );
`else
   assign psc  = '0;
   assign tick = 1'b1;
`endif

   // Next-state logic; modes 10 and 11 fall through to one-shot behaviour.
   always_comb begin
      state_next   = state;
      count_next   = count;
      en_next      = en_wr;
      pending_next = bus_wr ? 1'b0 : pending;
      case (state)
         IDLE: begin
            if (en)
               state_next = LOAD;
         end
         LOAD: begin
            count_next   = preset;
            pending_next = 1'b0;
            state_next   = en_wr ? CNT : IDLE;
         end
         CNT: begin
            if (!en_wr)
               state_next = IDLE;
            else if (tick) begin
               if (count > CNT_W'(1))
                  count_next = count - CNT_W'(1);
               else begin
                  count_next = '0;
                  state_next = INT;
               end
            end
         end
         INT: begin
            if (!bus_wr)
               pending_next = 1'b1;
            if ((mode_wr == MODE_RELOAD) && en_wr)
               state_next = LOAD;
            else begin
               state_next = IDLE;
               if (!ctrl_wr)
                  en_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // irq is registered from the post-edge mask and pending values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         en      <= 1'b0;
         mode    <= MODE_ONESHOT;
         im      <= 1'b0;
         preset  <= '0;
         count   <= '0;
         pending <= 1'b0;
         irq     <= 1'b0;
      end else begin
         state   <= state_next;
         en      <= en_next;
         mode    <= mode_wr;
         im      <= im_wr;
         count   <= count_next;
         pending <= pending_next;
         irq     <= im_wr & pending_next;
         if (preset_wr)
            preset <= din[CNT_W-1:0];
      end
   end

   always_comb begin
      dout = 32'd0;
      case (addr)
         ADDR_CTRL:   dout = ctrl_read(en, mode, im);
         ADDR_PRESET: dout = 32'(preset);
         ADDR_COUNT:  dout = 32'(count);
         ADDR_PSC:    dout = 32'(psc);
         default:     dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: a cycle-by-cycle vector table plus
// hand-written sequences for asynchronous reset and auto-reload pulses.
module tb_timer_dev;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int errorCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   timer_dev dut (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .addr (addr),
      .din  (din),
      .dout (dout),
      .irq  (irq)
   );

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] din;
      logic [31:0] expDout;
      logic        expIrq;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input logic w, input logic [1:0] a, input logic [31:0] d,
                                  input logic [31:0] ed, input logic ei);
      vec_t v;
      v.we      = w;
      v.addr    = a;
      v.din     = d;
      v.expDout = ed;
      v.expIrq  = ei;
      vecs.push_back(v);
   endfunction

   // Drive one bus cycle, then sample just after the rising edge.
   task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
      we   = w;
      addr = a;
      din  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expDout, input logic expIrq);
      checkCount++;
      if (dout !== expDout) begin
         errorCount++;
         $display("[TB] FAIL %s: dout=0x%08h expected 0x%08h", name, dout, expDout);
      end
      checkCount++;
      if (irq !== expIrq) begin
         errorCount++;
         $display("[TB] FAIL %s: irq=%b expected %b", name, irq, expIrq);
      end
   endtask

   initial begin
      logic [31:0] expCount;
      logic        expIrq;
      int          phase;

      rst  = 1'b1;
      we   = 1'b0;
      addr = 2'd0;
      din  = 32'd0;
      #2;
      checkOutput("reset_held", 32'd0, 1'b0);
      #10;
      rst = 1'b0;

      // Reset state at every address
      addVec(0, 0, 0, 0, 0);
      addVec(0, 1, 0, 0, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 3, 0, 0, 0);
      // One-shot: PRESET=5, CTRL=0x9 at edge k, irq after k+8
      addVec(1, 1, 5, 5, 0);
      addVec(1, 0, 32'h9, 32'h9, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 2, 0, 5, 0);
      addVec(0, 2, 0, 4, 0);
      addVec(0, 2, 0, 3, 0);
      addVec(0, 2, 0, 2, 0);
      addVec(0, 2, 0, 1, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 2, 0, 0, 1);
      addVec(0, 0, 0, 32'h8, 1);
      addVec(1, 0, 0, 0, 0);
      addVec(0, 2, 0, 0, 0);
      // Abort mid-count at COUNT=2, then re-enable and abort again at 4
      addVec(1, 1, 4, 4, 0);
      addVec(1, 0, 32'h9, 32'h9, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 2, 0, 4, 0);
      addVec(0, 2, 0, 3, 0);
      addVec(0, 2, 0, 2, 0);
      addVec(1, 0, 0, 0, 0);
      addVec(0, 2, 0, 2, 0);
      addVec(0, 2, 0, 2, 0);
      addVec(1, 0, 32'h9, 32'h9, 0);
      addVec(0, 2, 0, 2, 0);
      addVec(0, 2, 0, 4, 0);
      addVec(1, 0, 0, 0, 0);
      addVec(0, 2, 0, 4, 0);
      // Masked, PRESET=0 acts as 1; EN self-clears; COUNT write ignored
      addVec(1, 1, 0, 0, 0);
      addVec(1, 0, 32'h1, 32'h1, 0);
      addVec(0, 2, 0, 4, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 0, 0, 0, 0);
      addVec(1, 2, 32'h55, 0, 0);
      // CTRL write on the INT cycle suppresses pending
      addVec(1, 1, 2, 2, 0);
      addVec(1, 0, 32'h9, 32'h9, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 2, 0, 2, 0);
      addVec(0, 2, 0, 1, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(1, 0, 32'h8, 32'h8, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 0, 0, 32'h8, 0);
      addVec(1, 0, 0, 0, 0);
`ifdef TIMER_PRESCALE_EN
      // PSC=1, PRESET=2 (still loaded), CTRL=0x9 at edge k -> irq after k+7
      addVec(1, 3, 1, 1, 0);
      addVec(1, 0, 32'h9, 32'h9, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 2, 0, 2, 0);
      addVec(0, 2, 0, 2, 0);
      addVec(0, 2, 0, 1, 0);
      addVec(0, 2, 0, 1, 0);
      addVec(0, 2, 0, 0, 0);
      addVec(0, 2, 0, 0, 1);
      addVec(1, 0, 0, 0, 0);
      addVec(1, 3, 0, 0, 0);
`else
      addVec(1, 3, 32'h7, 0, 0);
      addVec(0, 3, 0, 0, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].din);
         checkOutput($sformatf("vec%0d", i), vecs[i].expDout, vecs[i].expIrq);
      end

      // Asynchronous reset in the middle of a count
      applyStimulus(1, 1, 5);
      applyStimulus(1, 0, 32'h9);
      repeat (4) applyStimulus(0, 2, 0);
      checkOutput("precount", 32'd3, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_async", 32'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 1, 0);
      checkOutput("rst_preset", 32'd0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 2, 0);
         checkOutput($sformatf("rst_idle%0d", i), 32'd0, 1'b0);
      end
      applyStimulus(0, 0, 0);
      checkOutput("rst_ctrl", 32'd0, 1'b0);

      // Auto-reload PRESET=3: one-cycle pulse every 5 cycles
      applyStimulus(1, 1, 3);
      applyStimulus(1, 0, 32'hB);
      checkOutput("reload_ctrl", 32'hB, 1'b0);
      for (int off = 1; off <= 22; off++) begin
         applyStimulus(0, 2, 0);
         if (off < 2)
            expCount = 32'd0;
         else begin
            phase = (off - 2) % 5;
            expCount = (phase < 3) ? 32'(3 - phase) : 32'd0;
         end
         expIrq = (off >= 6) && (((off - 6) % 5) == 0);
         checkOutput($sformatf("reload%0d", off), expCount, expIrq);
      end
      applyStimulus(0, 0, 0);
      checkOutput("reload_en", 32'hB, 1'b0);
      applyStimulus(1, 0, 0);
      checkOutput("reload_stop", 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
